// File: rtl/div_arb_pkg.sv
// Shared types and default sizes for the divider arbiter and its round-robin selector.
// The tag struct is sized from these defaults, so div_arbiter parameters must agree with them.
package div_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DIVINDED_WIDTH = 8;
    localparam int DEF_DIVISOR_WIDTH  = 8;
    localparam int DEF_DIV_LATENCY    = 8;
    localparam int ID_WIDTH           = $clog2(DEF_NUM_REQ);

    typedef enum logic {
        REQ_IDLE    = 1'b0,
        REQ_PENDING = 1'b1
    } req_state_t;

    typedef struct packed {
        logic                          valid;
        logic [ID_WIDTH-1:0]           id;
        logic                          dz;
        logic [DEF_DIVINDED_WIDTH-1:0] dividend;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant among requesting lines, searching from one above
// the last accepted index; the pointer only moves when the grant is actually accepted.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_WIDTH-1:0] last;
    logic [PTR_WIDTH-1:0] winner;
    logic [PTR_WIDTH-1:0] cand;

    always_comb begin
        grant  = '0;
        winner = last;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_WIDTH'((int'(last) + k) % NUM_REQ);
            if (grant == '0 && req[cand]) begin
                grant[cand] = 1'b1;
                winner      = cand;
            end
        end
    end

    // Reset pointer to the top index so index 0 has first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= PTR_WIDTH'(NUM_REQ - 1);
        end else if (accept) begin
            last <= winner;
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one fixed-latency pipelined divider among NUM_REQ requesters, tracking each
// issue with a tag that travels alongside the divider pipeline to route results back.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DIVINDED_WIDTH = DEF_DIVINDED_WIDTH,
    parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
    parameter int DIV_LATENCY    = DEF_DIV_LATENCY
) (
    input  logic                                    clk_i,
    input  logic                                    rst_n_i,
    input  logic [NUM_REQ-1:0]                      req_valid_i,
    output logic [NUM_REQ-1:0]                      req_ready_o,
    input  logic [NUM_REQ-1:0][DIVINDED_WIDTH-1:0]  req_divinded_i,
    input  logic [NUM_REQ-1:0][DIVISOR_WIDTH-1:0]   req_divisor_i,
    output logic [NUM_REQ-1:0]                      rsp_valid_o,
    output logic [DIVINDED_WIDTH-1:0]               rsp_quotient_o,
    output logic [DIVISOR_WIDTH-1:0]                rsp_reminder_o,
    output logic                                    div_valid_o,
    output logic [DIVINDED_WIDTH-1:0]               div_divinded_o,
    output logic [DIVISOR_WIDTH-1:0]                div_divisor_o,
    input  logic                                    div_valid_i,
    input  logic [DIVINDED_WIDTH-1:0]               div_quotient_i,
    input  logic [DIVISOR_WIDTH-1:0]                div_reminder_i,
    output logic                                    error_o
);

    req_state_t          state      [NUM_REQ];
    req_state_t          state_next [NUM_REQ];
    logic [NUM_REQ-1:0]  idle;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  done;
    logic                accept;
    logic [ID_WIDTH-1:0] grant_id;
    logic [ID_WIDTH-1:0] issue_id;
    logic                issue_dz;
    tag_t                pipe [DIV_LATENCY];
    tag_t                head;
    logic                rsp_ok;
    logic                spurious;

    assign eligible    = req_valid_i & idle;
    assign req_ready_o = grant;
    assign accept      = |grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .req    (eligible),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state[i] <= REQ_IDLE;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                state[i] <= state_next[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            state_next[i] = state[i];
            case (state[i])
                REQ_IDLE:    if (grant[i]) state_next[i] = REQ_PENDING;
                REQ_PENDING: if (done[i])  state_next[i] = REQ_IDLE;
                default:     state_next[i] = REQ_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            idle[i] = (state[i] == REQ_IDLE);
            done[i] = rsp_ok && (head.id == ID_WIDTH'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_valid_o    <= 1'b0;
            div_divinded_o <= '0;
            div_divisor_o  <= '0;
            issue_id       <= '0;
            issue_dz       <= 1'b0;
        end else begin
            div_valid_o <= accept;
            if (accept) begin
                div_divinded_o <= req_divinded_i[grant_id];
                div_divisor_o  <= req_divisor_i[grant_id];
                issue_id       <= grant_id;
                issue_dz       <= (req_divisor_i[grant_id] == '0);
            end
        end
    end

    // Tag enters as the divider samples its operands, so the head lines up with div_valid_i.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < DIV_LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: div_valid_o, id: issue_id, dz: issue_dz, dividend: div_divinded_o};
            for (int k = 1; k < DIV_LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign head     = pipe[DIV_LATENCY-1];
    assign rsp_ok   = div_valid_i & head.valid;
    assign spurious = div_valid_i ^ head.valid;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_o    <= '0;
            rsp_quotient_o <= '0;
            rsp_reminder_o <= '0;
            error_o        <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            if (rsp_ok) begin
                rsp_valid_o[head.id] <= 1'b1;
                rsp_quotient_o       <= head.dz ? '1 : div_quotient_i;
                rsp_reminder_o       <= head.dz ? head.dividend[DIVISOR_WIDTH-1:0] : div_reminder_i;
            end
            if (spurious) begin
                error_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one divider.
REQ-002 Parameter DIVINDED_WIDTH, default 8: dividend/quotient width.
REQ-003 Parameter DIVISOR_WIDTH, default 8: divisor/remainder width.
REQ-004 Parameter DIV_LATENCY, default 8: fixed cycles from divider valid input to its valid output.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset.
REQ-007 req_valid_i  in  NUM_REQ  per-requester request strobe.
REQ-008 req_ready_o  out  NUM_REQ  per-requester accept.
REQ-009 req_divinded_i  in  NUM_REQ x DIVINDED_WIDTH  dividends.
REQ-010 req_divisor_i  in  NUM_REQ x DIVISOR_WIDTH  divisors.
REQ-011 rsp_valid_o  out  NUM_REQ  one-cycle result pulse per requester.
REQ-012 rsp_quotient_o  out  DIVINDED_WIDTH  shared result quotient.
REQ-013 rsp_reminder_o  out  DIVISOR_WIDTH  shared result remainder.
REQ-014 div_valid_o / div_divinded_o / div_divisor_o  out  1 / DIVINDED_WIDTH / DIVISOR_WIDTH  issue to pipeline_division.
REQ-015 div_valid_i / div_quotient_i / div_reminder_i  in  1 / DIVINDED_WIDTH / DIVISOR_WIDTH  result from pipeline_division.
REQ-016 error_o  out  1  sticky tag/result mismatch flag.

Function
REQ-017 Each requester SHALL have state IDLE or PENDING; at most one outstanding request per requester.
REQ-018 req_ready_o[i] SHALL be high only when requester i is IDLE and i holds the current round-robin grant.
REQ-019 Acceptance (req_valid_i[i] & req_ready_o[i] at a rising edge) SHALL move i IDLE->PENDING.
REQ-020 At most one request SHALL be accepted per cycle; grant is round-robin among IDLE requesters with valid asserted, priority starting one above the last granted index, wrapping NUM_REQ-1 -> 0.
REQ-021 Operands SHALL be registered: div_valid_o high exactly in the cycle after acceptance, with captured dividend/divisor; div_valid_o low otherwise.
REQ-022 On each issue, tag {valid, id, dz, dividend} SHALL enter a DIV_LATENCY-deep shift register aligned with the divider pipeline.
REQ-023 When div_valid_i is high, the head tag SHALL be valid; the result SHALL be registered and rsp_valid_o[id] pulsed high one cycle later; id returns PENDING->IDLE in that same cycle.
REQ-024 Total latency acceptance edge to rsp_valid_o SHALL be DIV_LATENCY + 2 cycles; throughput one request per cycle.
REQ-025 Divisor zero: request still issued (ordering preserved); response SHALL override to quotient all-ones, remainder = dividend[DIVISOR_WIDTH-1:0].
REQ-026 A returning requester MAY be re-granted in the cycle its rsp_valid_o pulses (IDLE update visible to arbitration that cycle).
REQ-027 div_valid_i high with invalid head tag, or valid head tag without div_valid_i, SHALL set error_o until reset; no rsp_valid_o on a spurious result.
REQ-028 rsp_quotient_o/rsp_reminder_o SHALL hold last value when rsp_valid_o is all-zero.

Reset
REQ-029 Reset assertion SHALL immediately clear: all requesters IDLE, req_ready_o derived accordingly, rsp_valid_o 0, div_valid_o 0, div operands 0, rsp data 0, tag shift register invalid, round-robin pointer to NUM_REQ-1 (index 0 highest priority), error_o 0.
REQ-030 Reset mid-operation SHALL discard in-flight tags; later divider results without valid tags SHALL set error_o only if they arrive after reset deasserts and the divider was not also reset.

Structure
REQ-031 Package div_arb_pkg SHALL hold tag struct typedef, requester-state enum, and id-width constant $clog2(NUM_REQ).
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (request vector in, one-hot grant out, pointer update on accept).

Verification
REQ-033 Single request: requester 0 sends 200/7 -> rsp_valid_o[0] at DIV_LATENCY+2 cycles, quotient 28, remainder 4.
REQ-034 All four request same cycle, repeatedly -> grants 0,1,2,3 in order, one issue/cycle, each result routed to its own index.
REQ-035 Divide by zero: 55/0 -> quotient 255, remainder 55, error_o stays 0.
REQ-036 Back-to-back: requester 2 re-requests in its response cycle -> accepted that cycle, no bubble.
REQ-037 Forced div_valid_i with empty tag pipe -> error_o 1 next cycle, no rsp_valid_o.
REQ-038 Reset asserted with 3 requests in flight -> all outputs 0 immediately, all req_ready_o eligible after deassert, 100 random requests then match a golden model.
